// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable clock divider and tick generator
// Optional per-channel tick event counter enabled by defining CLKDIV_EVCNT_EN.
module clk_div_multi #(
    parameter int CH    = 2,
    parameter int CNT_W = 14,
    parameter int EVC_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH-1:0]         en,
    input  logic [CH-1:0]         clr,
    input  logic [CH*CNT_W-1:0]   div_val,
`ifdef CLKDIV_EVCNT_EN
    output logic [CH*EVC_W-1:0]   ev_cnt,
`endif
    output logic [CH-1:0]         clk_out,
    output logic [CH-1:0]         tick
);

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] dv;
        logic [CNT_W-1:0] term;
        logic             co_q;
        logic             tick_q;
        logic             at_term;

        assign dv = div_val[g*CNT_W +: CNT_W];
        // A zero divide value behaves as divide-by-one, so the terminal count is 0 in both cases.
        assign term    = (dv == '0) ? '0 : dv - 1'b1;
        assign at_term = (cnt >= term);

        always_ff @(posedge clk) begin
            if (rst_n || clr[g]) begin
                cnt    <= '0;
                co_q   <= 1'b0;
                tick_q <= 1'b0;
            end else if (en[g]) begin
                if (at_term) begin
                    cnt    <= '0;
                    co_q   <= ~co_q;
                    tick_q <= 1'b1;
                end else begin
                    cnt    <= cnt + 1'b1;
                    tick_q <= 1'b0;
                end
            end else begin
                tick_q <= 1'b0;
            end
        end

        assign clk_out[g] = co_q;
        assign tick[g]    = tick_q;

`ifdef CLKDIV_EVCNT_EN
        logic [EVC_W-1:0] ev_q;

        // Counts the same edges that register tick high; wraps naturally.
        always_ff @(posedge clk) begin
            if (rst_n || clr[g]) begin
                ev_q <= '0;
            end else if (en[g] && at_term) begin
                ev_q <= ev_q + 1'b1;
            end
        end

        assign ev_cnt[g*EVC_W +: EVC_W] = ev_q;
`endif
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
// Exercises the event counter too when built with CLKDIV_EVCNT_EN.
module tb_clk_div_multi;
    localparam int CH    = 2;
    localparam int CNT_W = 14;
    localparam int EVC_W = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [CH-1:0]       en;
    logic [CH-1:0]       clr;
    logic [CH*CNT_W-1:0] div_val;
    logic [CH-1:0]       clk_out;
    logic [CH-1:0]       tick;
`ifdef CLKDIV_EVCNT_EN
    logic [CH*EVC_W-1:0] ev_cnt;
`endif

    int tests = 0;
    int fails = 0;

    clk_div_multi #(.CH(CH), .CNT_W(CNT_W), .EVC_W(EVC_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .div_val (div_val),
`ifdef CLKDIV_EVCNT_EN
        .ev_cnt  (ev_cnt),
`endif
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    // Expected state after n enabled edges from a cleared channel with divide d.
    function automatic logic m_tick(input int n, input int d);
        return (n > 0) && ((n % d) == 0);
    endfunction

    function automatic logic m_clk(input int n, input int d);
        return ((n / d) % 2) == 1;
    endfunction

    task automatic set_div(input int d0, input int d1);
        div_val = {d1[CNT_W-1:0], d0[CNT_W-1:0]};
    endtask

    task automatic restart();
        @(negedge clk) clr = 2'b11;
        @(negedge clk) clr = 2'b00;
    endtask

    task automatic test_reset();
        logic [1:0] et, ec;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (clk_out !== 2'b00 || tick !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold cyc %0d: clk_out=%b tick=%b, need 00 00", i, clk_out, tick);
            end
        end
        rst_n = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            et = {m_tick(n, 5), m_tick(n, 3)};
            ec = {m_clk(n, 5), m_clk(n, 3)};
            tests++;
            if (tick !== et || clk_out !== ec) begin
                fails++;
                $display("FAIL reset_release edge %0d: tick=%b clk_out=%b, need %b %b", n, tick, clk_out, et, ec);
            end
        end
    endtask

    task automatic test_steady();
        int t0 = 0, t1 = 0, e0 = 0, e1 = 0, hi0 = 0;
        set_div(10000, 16383);
        en = 2'b11;
        restart();
        for (int n = 1; n <= 60000; n++) begin
            @(negedge clk);
            if (tick[0]) t0++;
            if (tick[1]) t1++;
            if (clk_out[0]) hi0++;
            if (tick[0] !== m_tick(n, 10000) || clk_out[0] !== m_clk(n, 10000)) e0++;
            if (tick[1] !== m_tick(n, 16383) || clk_out[1] !== m_clk(n, 16383)) e1++;
        end
        tests++;
        if (t0 !== 6) begin fails++; $display("FAIL steady_ticks0: got %0d, need 6", t0); end
        tests++;
        if (t1 !== 3) begin fails++; $display("FAIL steady_ticks1: got %0d, need 3", t1); end
        tests++;
        if (hi0 !== 30000) begin fails++; $display("FAIL steady_duty0: high %0d, need 30000", hi0); end
        tests++;
        if (e0 !== 0) begin fails++; $display("FAIL steady_seq0: %0d bad cycles, need 0", e0); end
        tests++;
        if (e1 !== 0) begin fails++; $display("FAIL steady_seq_max: %0d bad cycles, need 0", e1); end
    endtask

    task automatic test_edge_values();
        logic [1:0] ec;
        set_div(0, 1);
        en = 2'b11;
        restart();
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            ec = (n % 2 == 1) ? 2'b11 : 2'b00;
            tests++;
            if (tick !== 2'b11 || clk_out !== ec) begin
                fails++;
                $display("FAIL div01 edge %0d: tick=%b clk_out=%b, need 11 %b", n, tick, clk_out, ec);
            end
        end
    endtask

    task automatic test_shrink();
        int early = 0;
        logic ec;
        set_div(100, 4);
        en = 2'b01;
        restart();
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (tick !== 2'b00) early++;
        end
        tests++;
        if (early !== 0) begin fails++; $display("FAIL shrink_pre: %0d ticks, need 0", early); end
        set_div(10, 4);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            ec = (((k - 1) / 10) % 2) == 0;
            tests++;
            if (tick[0] !== (k % 10 == 1) || clk_out[0] !== ec || tick[1] !== 1'b0) begin
                fails++;
                $display("FAIL shrink edge %0d: tick=%b clk_out0=%b, need tick0=%b tick1=0 clk_out0=%b",
                         k, tick, clk_out[0], (k % 10 == 1), ec);
            end
        end
    endtask

    task automatic test_hold();
        logic [1:0] et, ec;
        set_div(5, 4);
        en = 2'b11;
        restart();
        for (int n = 1; n <= 7; n++) @(negedge clk);
        en = 2'b00;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            tests++;
            if (tick !== 2'b00 || clk_out !== 2'b11) begin
                fails++;
                $display("FAIL hold cyc %0d: tick=%b clk_out=%b, need 00 11", i, tick, clk_out);
            end
        end
        en = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            et = {m_tick(7 + k, 4), m_tick(7 + k, 5)};
            ec = {m_clk(7 + k, 4), m_clk(7 + k, 5)};
            tests++;
            if (tick !== et || clk_out !== ec) begin
                fails++;
                $display("FAIL resume edge %0d: tick=%b clk_out=%b, need %b %b", k, tick, clk_out, et, ec);
            end
        end
    endtask

    task automatic test_clr_terminal();
        logic [1:0] et, ec;
        set_div(3, 4);
        en = 2'b11;
        restart();
        for (int n = 1; n <= 5; n++) @(negedge clk);
        clr = 2'b01;
        @(negedge clk);
        tests++;
        if (tick !== 2'b00 || clk_out !== 2'b10) begin
            fails++;
            $display("FAIL clr_terminal: tick=%b clk_out=%b, need 00 10", tick, clk_out);
        end
        clr = 2'b00;
        for (int n = 7; n <= 20; n++) begin
            @(negedge clk);
            et = {m_tick(n, 4), m_tick(n - 6, 3)};
            ec = {m_clk(n, 4), m_clk(n - 6, 3)};
            tests++;
            if (tick !== et || clk_out !== ec) begin
                fails++;
                $display("FAIL after_clr edge %0d: tick=%b clk_out=%b, need %b %b", n, tick, clk_out, et, ec);
            end
        end
    endtask

`ifdef CLKDIV_EVCNT_EN
    task automatic test_evcnt();
        int errs = 0;
        set_div(2, 1);
        en = 2'b01;
        restart();
        tests++;
        if (ev_cnt !== '0) begin fails++; $display("FAIL ev_start: got %0h, need 0", ev_cnt); end
        for (int n = 1; n <= 514; n++) begin
            @(negedge clk);
            if (ev_cnt[7:0] !== 8'((n / 2) % 256) || ev_cnt[15:8] !== 8'd0) errs++;
            if (n == 510) begin
                tests++;
                if (ev_cnt[7:0] !== 8'd255) begin fails++; $display("FAIL ev_max: got %0d, need 255", ev_cnt[7:0]); end
            end
            if (n == 512) begin
                tests++;
                if (ev_cnt[7:0] !== 8'd0) begin fails++; $display("FAIL ev_wrap: got %0d, need 0", ev_cnt[7:0]); end
            end
        end
        tests++;
        if (errs !== 0) begin fails++; $display("FAIL ev_seq: %0d bad cycles, need 0", errs); end
        restart();
        tests++;
        if (ev_cnt !== '0) begin fails++; $display("FAIL ev_clr: got %0h, need 0", ev_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        en    = 2'b11;
        clr   = 2'b00;
        set_div(3, 5);
        test_reset();
        test_steady();
        test_edge_values();
        test_shrink();
        test_hold();
        test_clr_terminal();
`ifdef CLKDIV_EVCNT_EN
        test_evcnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, fully synchronous multi-channel clock divider and tick generator. It replaces single-channel fixed divide-by-10000 dividers that use a derived-clock reset.
- Each channel has a run-time programmable terminal count, an enable and a restart (clear).
- Each channel produces a 50%-duty divided square wave and a one-cycle tick strobe.
- All state lives in the `clk` domain. Consumers use `tick` as a clock enable rather than clocking logic from `clk_out`.

Parameters:
- CH, 2, number of independent divider channels (1..8).
- CNT_W, 14, counter and divide-value width per channel.
- EVC_W, 8, event-counter width (used only with the optional feature).

Ports:
- clk  input  1  system clock; all logic is clocked on its rising edge.
- rst_n  input  1  reset, synchronous and active-high despite the `_n` suffix; asserted (1) resets every channel on the next rising clk edge.
- en  input  CH  per-channel count enable; bit i controls channel i.
- clr  input  CH  per-channel synchronous restart, one-cycle or level.
- div_val  input  CH*CNT_W  per-channel terminal count; channel i uses bits [i*CNT_W +: CNT_W].
- clk_out  output  CH  per-channel divided clock; toggles at each terminal event.
- tick  output  CH  per-channel one-cycle strobe, coincident with each clk_out toggle.

Behaviour:
- Per-channel state: cnt[CNT_W-1:0], clk_out bit, tick bit. All outputs are registered.
- Effective divide value: div_eff = (div_val_i == 0) ? 1 : div_val_i. There is no divide-by-zero stall.
- Priority per channel per rising edge: rst_n > clr > en > hold.
- rst_n = 1: cnt <= 0, clk_out <= 0, tick <= 0 for all channels, regardless of en or clr.
- clr_i = 1 (rst_n = 0): cnt <= 0, clk_out_i <= 0, tick_i <= 0. Other channels are unaffected.
- en_i = 1, no clr:
  - If cnt >= div_eff-1 (terminal): cnt <= 0, tick_i <= 1, clk_out_i <= ~clk_out_i.
  - Otherwise: cnt <= cnt+1, tick_i <= 0.
- en_i = 0: cnt and clk_out_i hold; tick_i <= 0.
- Timing:
  - Terminal events occur every div_eff enabled cycles.
  - clk_out period = 2*div_eff clk cycles.
  - The first tick is registered high exactly div_eff rising edges after the first edge at which en is sampled high following reset or clr.
- div_eff = 1: tick stays high continuously while enabled, and clk_out = clk/2.
- div_val changed mid-count:
  - The new value is used from the next edge.
  - If cnt is already >= new div_eff-1, the next enabled edge is terminal. The compare is >=, so the counter never runs to wrap-around.
- The counter cannot overflow: cnt max = 2^CNT_W - 2, since div_eff-1 <= 2^CNT_W - 2.
- Channels are independent. Identical settings released together stay phase-locked.
- Simultaneous clr_i and terminal condition: clr wins; no tick.

Optional Feature:
- Macro: CLKDIV_EVCNT_EN.
- Defined:
  - Adds output port ev_cnt, width CH*EVC_W.
  - Per channel, ev_cnt increments by 1 on every edge at which tick is registered high, and wraps 2^EVC_W-1 -> 0.
  - Cleared to 0 by rst_n or clr_i, with the same priority as cnt.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan:
- Reset: rst_n = 1 for 3 cycles with en = 2'b11 and div_val = {14'd5, 14'd3} -> clk_out = 0, tick = 0 throughout. Release -> ch0 first tick 3 edges after en is sampled; ch1 after 5.
- Steady state: CH = 2, div_val ch0 = 10000, en = 1 for 60000 cycles -> ch0 tick every 10000 cycles, clk_out period 20000 with 50% duty, exactly 6 ticks.
- Edge values: div_val = 0 and div_val = 1 -> tick constant 1 while enabled, clk_out toggles every cycle. div_val = 16383 -> period 32766, no overflow.
- Shrink mid-count: div_val 100 -> 10 while cnt = 50 -> tick on the next edge, then every 10 cycles.
- Hold and restart: en low for 7 cycles mid-count -> cnt and clk_out hold, tick = 0, then resume. clr pulse coincident with terminal -> no tick, clk_out = 0, other channel's period undisturbed.
- CLKDIV_EVCNT_EN, EVC_W = 8, div_val = 2 -> ev_cnt counts 0..255, wraps to 0 after 256 ticks. clr -> 0.
